// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter holds DWIDTH-1 down to 0.
  function automatic int cnt_width(input int dwidth);
    return (dwidth < 2) ? 1 : $clog2(dwidth);
  endfunction

  // Quotient reported on divide-by-zero; sliced to DWIDTH by the user.
  localparam logic [63:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/divider_seq_div_sub_step.sv
// One restoring-division step: (W+1)-bit trial subtract, MSB of the result is the borrow.
module div_sub_step #(
  parameter int W = 4
) (
  input  logic [W:0]   minuend,
  input  logic [W-1:0] subtrahend,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W:0] full;

  assign full   = minuend - {1'b0, subtrahend};
  assign diff   = full[W-1:0];
  assign borrow = full[W];

endmodule

// File: rtl/divider_seq.sv
// Iterative restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Define DIVIDER_SIGNED_EN to honour signed_sel (two's-complement divide with overflow flag).
module divider_seq
  import divider_pkg::*;
#(
  parameter int DWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  input  logic              signed_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] quotient,
  output logic [DWIDTH-1:0] remainder,
  output logic              div_zero,
  output logic              overflow
);

  localparam int CW = cnt_width(DWIDTH);

  state_t            state, state_nxt;
  logic [DWIDTH-1:0] rem_q, dvd_q, dvs_q;
  logic [CW-1:0]     cnt;
  logic [DWIDTH-1:0] a_mag, b_mag;
  logic              is_ovf, b_zero;
  logic [DWIDTH-1:0] step_q, step_r, step_diff, q_fix, r_fix;
  logic [DWIDTH:0]   minuend;
  logic              step_borrow;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign b_zero    = (b == '0);

`ifdef DIVIDER_SIGNED_EN
  localparam logic [DWIDTH-1:0] MOST_NEG = {1'b1, {(DWIDTH-1){1'b0}}};
  logic a_neg, b_neg, neg_q, neg_r;

  always_comb begin
    a_neg  = signed_sel & a[DWIDTH-1];
    b_neg  = signed_sel & b[DWIDTH-1];
    // Negating MOST_NEG yields itself, which is its correct unsigned magnitude.
    a_mag  = a_neg ? -a : a;
    b_mag  = b_neg ? -b : b;
    is_ovf = signed_sel && (a == MOST_NEG) && (b == '1);
    q_fix  = neg_q ? -step_q : step_q;
    r_fix  = neg_r ? -step_r : step_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
    end
  end
`else
  logic unused_signed_sel;

  assign unused_signed_sel = signed_sel;

  always_comb begin
    a_mag  = a;
    b_mag  = b;
    is_ovf = 1'b0;
    q_fix  = step_q;
    r_fix  = step_r;
  end
`endif

  // Partial remainder stays below the divisor, so one extra bit holds the shifted value.
  assign minuend = {rem_q, dvd_q[DWIDTH-1]};

  div_sub_step #(.W(DWIDTH)) u_step (
    .minuend    (minuend),
    .subtrahend (dvs_q),
    .diff       (step_diff),
    .borrow     (step_borrow)
  );

  assign step_r = step_borrow ? minuend[DWIDTH-1:0] : step_diff;
  assign step_q = {dvd_q[DWIDTH-2:0], ~step_borrow};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: next state defaults to the current state first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = (b_zero || is_ovf) ? DONE : CALC;
      CALC:    if (cnt == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          div_zero <= b_zero;
          overflow <= !b_zero && is_ovf;
          if (b_zero) begin
            quotient  <= DIV_ZERO_QUOT[DWIDTH-1:0];
            remainder <= a;
          end else if (is_ovf) begin
            quotient  <= a;
            remainder <= '0;
          end else begin
            rem_q <= '0;
            dvd_q <= a_mag;
            dvs_q <= b_mag;
            cnt   <= CW'(DWIDTH - 1);
          end
        end
        CALC: begin
          rem_q <= step_r;
          dvd_q <= step_q;
          cnt   <= cnt - 1'b1;
          if (cnt == '0) begin
            quotient  <= q_fix;
            remainder <= r_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq (DWIDTH=4): vector table, scoreboard queue, corner sequences.
module tb_divider_seq;

  localparam int DW = 4;
`ifdef DIVIDER_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    logic          dz;
    logic          ov;
    int            lat;
  } res_t;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          s;
    int            hold;
    res_t          exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, signed_sel, out_valid, out_ready;
  logic          div_zero, overflow;
  logic [DW-1:0] a, b, quotient, remainder;

  int   n_cmp = 0;
  int   n_bad = 0;
  res_t sb[$];

  always #5 clk = ~clk;

  divider_seq #(.DWIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .signed_sel (signed_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_zero   (div_zero),
    .overflow   (overflow)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference built on the language's own division operators.
  function automatic res_t model(input logic [DW-1:0] ta, input logic [DW-1:0] tb_, input logic ts);
    res_t r;
    int   sa, sd;
    r.dz = 1'b0; r.ov = 1'b0; r.lat = DW + 1;
    if (tb_ == '0) begin
      r.q = '1; r.r = ta; r.dz = 1'b1; r.lat = 1;
    end else if (SIGNED_BUILD && ts && ta == 4'h8 && tb_ == 4'hF) begin
      r.q = ta; r.r = '0; r.ov = 1'b1; r.lat = 1;
    end else if (SIGNED_BUILD && ts) begin
      sa = int'($signed(ta));
      sd = int'($signed(tb_));
      r.q = DW'(sa / sd);
      r.r = DW'(sa % sd);
    end else begin
      r.q = ta / tb_;
      r.r = ta % tb_;
    end
    return r;
  endfunction

  function automatic res_t mk(input logic [DW-1:0] q, input logic [DW-1:0] r, input logic dz,
                              input logic ov, input int lat);
    res_t x;
    x.q = q; x.r = r; x.dz = dz; x.ov = ov; x.lat = lat;
    return x;
  endfunction

  // One full transaction; keep_valid leaves in_valid high with junk operands while busy.
  task automatic do_op(input string tag, input logic [DW-1:0] ta, input logic [DW-1:0] tb_,
                       input logic ts, input int hold, input bit keep_valid, input res_t exp);
    res_t got;
    int   lat;
    @(negedge clk);
    check({tag, " in_ready before accept"}, int'(in_ready), 1);
    a = ta; b = tb_; signed_sel = ts; in_valid = 1'b1;
    sb.push_back(exp);
    @(posedge clk); #1;
    if (keep_valid) begin a = '0; b = '0; signed_sel = ~ts; end
    else in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    got = sb.pop_front();
    check({tag, " latency"}, lat, got.lat);
    check({tag, " quotient"}, int'(quotient), int'(got.q));
    check({tag, " remainder"}, int'(remainder), int'(got.r));
    check({tag, " div_zero"}, int'(div_zero), int'(got.dz));
    check({tag, " overflow"}, int'(overflow), int'(got.ov));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " held out_valid"}, int'(out_valid), 1);
      check({tag, " held in_ready"}, int'(in_ready), 0);
      check({tag, " held quotient"}, int'(quotient), int'(got.q));
      check({tag, " held remainder"}, int'(remainder), int'(got.r));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, " in_ready after release"}, int'(in_ready), 1);
    check({tag, " out_valid after release"}, int'(out_valid), 0);
  endtask

  initial begin
    vec_t vecs[$];
    vec_t v;
    logic [DW-1:0] ra, rb;
    logic          rs;
    int            seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; signed_sel = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset in_ready", int'(in_ready), 1);
    check("reset out_valid", int'(out_valid), 0);
    check("reset quotient", int'(quotient), 0);
    check("reset remainder", int'(remainder), 0);
    check("reset flags", int'({div_zero, overflow}), 0);

    v.hold = 0;
    v.a = 4'hD; v.b = 4'h3; v.s = 1'b0; v.exp = mk(4'h4, 4'h1, 0, 0, 5); vecs.push_back(v);
    v.a = 4'h5; v.b = 4'h0; v.s = 1'b0; v.exp = mk(4'hF, 4'h5, 1, 0, 1); vecs.push_back(v);
    v.a = 4'h5; v.b = 4'h0; v.s = 1'b1; v.exp = mk(4'hF, 4'h5, 1, 0, 1); vecs.push_back(v);
    v.a = 4'h8; v.b = 4'hF; v.s = 1'b0; v.exp = mk(4'h0, 4'h8, 0, 0, 5); vecs.push_back(v);
    v.a = 4'hF; v.b = 4'h1; v.s = 1'b0; v.exp = mk(4'hF, 4'h0, 0, 0, 5); vecs.push_back(v);
    v.a = 4'h3; v.b = 4'h5; v.s = 1'b0; v.exp = mk(4'h0, 4'h3, 0, 0, 5); vecs.push_back(v);
    v.a = 4'h7; v.b = 4'h7; v.s = 1'b0; v.exp = mk(4'h1, 4'h0, 0, 0, 5); vecs.push_back(v);
    if (SIGNED_BUILD) begin
      v.a = 4'b1001; v.b = 4'b0010; v.s = 1'b1; v.exp = mk(4'b1101, 4'b1111, 0, 0, 5); vecs.push_back(v);
      v.a = 4'h8; v.b = 4'hF; v.s = 1'b1; v.exp = mk(4'h8, 4'h0, 0, 1, 1); vecs.push_back(v);
      v.a = 4'h7; v.b = 4'hE; v.s = 1'b1; v.exp = mk(4'hD, 4'h1, 0, 0, 5); vecs.push_back(v);
      v.a = 4'h8; v.b = 4'h3; v.s = 1'b1; v.exp = mk(4'hE, 4'hE, 0, 0, 5); vecs.push_back(v);
    end else begin
      v.a = 4'b1001; v.b = 4'b0010; v.s = 1'b1; v.exp = mk(4'h4, 4'h1, 0, 0, 5); vecs.push_back(v);
      v.a = 4'h8; v.b = 4'hF; v.s = 1'b1; v.exp = mk(4'h0, 4'h8, 0, 0, 5); vecs.push_back(v);
      v.a = 4'h7; v.b = 4'hE; v.s = 1'b1; v.exp = mk(4'h0, 4'h7, 0, 0, 5); vecs.push_back(v);
      v.a = 4'h8; v.b = 4'h3; v.s = 1'b1; v.exp = mk(4'h2, 4'h2, 0, 0, 5); vecs.push_back(v);
    end

    for (int i = 0; i < vecs.size(); i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].hold, 1'b0, vecs[i].exp);

    // Back-pressure with in_valid left high and junk operands while busy.
    do_op("bp 13/3", 4'hD, 4'h3, 1'b0, 3, 1'b1, mk(4'h4, 4'h1, 0, 0, 5));
    do_op("bp 5/0", 4'h5, 4'h0, 1'b0, 2, 1'b1, mk(4'hF, 4'h5, 1, 0, 1));

    for (int i = 0; i < 20; i++) begin
      ra = DW'($urandom_range(0, 15));
      rb = DW'($urandom_range(0, 15));
      rs = 1'($urandom_range(0, 1));
      do_op($sformatf("rnd%0d %0d/%0d s%0d", i, ra, rb, rs), ra, rb, rs, 0, 1'b0, model(ra, rb, rs));
    end

    // Reset two cycles into a 13/3 operation.
    @(negedge clk);
    a = 4'hD; b = 4'h3; signed_sel = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rst-abort out_valid seen", seen, 0);
    check("rst-abort in_ready", int'(in_ready), 1);
    check("rst-abort quotient", int'(quotient), 0);
    check("rst-abort remainder", int'(remainder), 0);
    check("rst-abort flags", int'({div_zero, overflow}), 0);
    do_op("after rst 9/2", 4'h9, 4'h2, 1'b0, 0, 1'b0, mk(4'h4, 4'h1, 0, 0, 5));

    check("scoreboard empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got hang, expected finish");
    $fatal(1, "timeout");
  end

endmodule
